vec_stream_ram: RTL
===================

# vec_stream_ram

Parametrised vector data memory for the vector CPU system: R lanes of N bits per word, with a CPU load/store port and a streaming read port. The stream port feeds the VGA display (or any frame consumer) through a small prefetch FIFO with valid/ready handshake. It is the successor of the fixed 6×8-bit data RAM with a raw VGA address port. It adds lane write enables, out-of-range protection, frame looping, start/end-of-frame markers and underrun accounting.

## Interface
- N, 8, lane width in bits
- R, 6, lanes per vector word
- DEPTH, 2048, words in array
- AW, 11, address width (≥ clog2(DEPTH))
- FIFO_DEPTH, 4, stream prefetch FIFO entries (power of 2, ≥2)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cpu_req  in  1  CPU access strobe this cycle
- cpu_we  in  1  1 = write, 0 = read (qualified by cpu_req)
- cpu_lane_en  in  R  per-lane write enable
- cpu_addr  in  AW  word address
- cpu_wd  in  R*N  write data, lane k at bits [k*N +: N]
- cpu_rd  out  R*N  read data
- oor_err  out  1  sticky: CPU accessed addr ≥ DEPTH
- stream_en  in  1  level; enables frame streaming
- frame_base  in  AW  first word of frame
- frame_len  in  AW  words per frame
- s_valid  out  1  stream word valid
- s_ready  in  1  consumer accepts word
- s_data  out  R*N  stream word
- s_sof  out  1  s_data is first word of frame
- s_eof  out  1  s_data is last word of frame
- busy  out  1  FSM not IDLE
- underrun_cnt  out  16  saturating underrun count

## Operation
- Single-port array; one access per cycle. CPU has absolute priority; stream fetch only in cycles with cpu_req=0.
- CPU write: lanes with cpu_lane_en[k]=1 updated; others unchanged. cpu_addr ≥ DEPTH: write dropped, oor_err←1.
- CPU read: cpu_rd registered; addr ≥ DEPTH returns 0 and sets oor_err. cpu_rd holds until next CPU read. oor_err cleared only by reset.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: when stream_en=1 and frame_len≠0, latch base/len, ptr←base, issued←0, go FETCH. frame_len=0 stays IDLE.
  - FETCH: issue fetch when cpu_req=0 and (FIFO occupancy + in-flight) < FIFO_DEPTH. ptr increments, wraps DEPTH-1→0. After len fetches issued, go DRAIN.
  - DRAIN: wait until FIFO empty and no fetch in flight.
    - If stream_en=1: relatch base/len, go FETCH (next frame).
    - Otherwise go IDLE.
  - stream_en=0 in FETCH: stop issuing, flush FIFO (s_valid←0 next cycle), discard in-flight word, go IDLE once nothing in flight.
- Markers: s_sof set on the word with frame index 0; s_eof set on index len-1. len=1 sets both on the same word.
- Underrun: underrun_cnt +1 per cycle with s_ready=1, FIFO empty, state FETCH. Saturates at 0xFFFF.

## Timing
- Reset values: cpu_rd=0, oor_err=0, s_valid=0, s_data=0, s_sof=0, s_eof=0, busy=0, underrun_cnt=0, FIFO empty, FSM IDLE. Array contents are not reset.
- CPU read latency 1: data on cpu_rd in the cycle after cpu_req.
- Write at cycle t, read of same address at t+1 returns the new data.
- Stream fetch latency: word enters FIFO one cycle after issue. s_valid rises 2 cycles after the FETCH entry cycle, with no CPU traffic.
- Handshake:
  - Transfer when s_valid & s_ready.
  - s_data, s_sof and s_eof are stable while s_valid=1 and s_ready=0.
  - FIFO push and pop in the same cycle are allowed. Full FIFO with s_ready=1 keeps full throughput.
- Sustained rate 1 word/cycle with cpu_req=0 and s_ready=1.
- Reset mid-frame: all state and outputs return to reset values immediately (asynchronous).

## Test plan
- Reset, write addr 5 lanes=all with 0x060504030201, read addr 5 → cpu_rd=0x060504030201 one cycle later; oor_err=0.
- Write 0xFFFFFFFFFFFF then lane_en=0b000010 with 0x00000000AA00 → read returns 0xFFFFFFFFAAFF.
- cpu_addr=DEPTH write then read → array unchanged, cpu_rd=0, oor_err=1 and stays 1.
- base=DEPTH-2, len=4, s_ready=1, stream_en=1 → words from addresses DEPTH-2, DEPTH-1, 0, 1; sof on first, eof on fourth. Frame repeats while stream_en=1.
- Streaming with s_ready=1 and cpu_req=1 held 10 cycles → no stream fetches, underrun_cnt increments once per empty-FIFO cycle. Output order is preserved afterwards.
- s_ready=0 until FIFO full, then stream_en=0 → s_valid=0 within 1 cycle, busy=0 after in-flight word drains, no sof/eof emitted.

Source files
------------

// File: rtl/vec_stream_ram.sv
// vec_stream_ram: R-lane vector data RAM with a CPU load/store port and a prefetching frame stream port.
//   clk, reset                      : clock, asynchronous active-low reset
//   cpu_req, cpu_we, cpu_lane_en    : CPU access strobe, write select, per-lane write enables
//   cpu_addr, cpu_wd, cpu_rd        : CPU word address, write data, registered read data
//   oor_err                         : sticky flag, CPU touched an address >= DEPTH
//   stream_en, frame_base, frame_len: frame streaming control
//   s_valid, s_ready, s_data        : stream word handshake
//   s_sof, s_eof                    : first / last word of frame markers
//   busy, underrun_cnt              : streaming active, saturating starvation count
module vec_stream_ram #(
    parameter int N          = 8,
    parameter int R          = 6,
    parameter int DEPTH      = 2048,
    parameter int AW         = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [R-1:0]    cpu_lane_en,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [R*N-1:0]  cpu_wd,
    output logic [R*N-1:0]  cpu_rd,
    output logic            oor_err,
    input  logic            stream_en,
    input  logic [AW-1:0]   frame_base,
    input  logic [AW-1:0]   frame_len,
    output logic            s_valid,
    input  logic            s_ready,
    output logic [R*N-1:0]  s_data,
    output logic            s_sof,
    output logic            s_eof,
    output logic            busy,
    output logic [15:0]     underrun_cnt
);
    localparam int W = R * N;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  ptr, len, issued, addr_sel;
    logic [W-1:0]   rd_word, fly_data;
    logic           fly, fly_sof, fly_eof;
    logic [W+1:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic           cpu_ok, empty, pop, push, flush, issue, relatch, last;

    // One array access per cycle: the CPU owns the port whenever it asks.
    assign addr_sel = cpu_req ? cpu_addr : ptr;
    assign rd_word  = (32'(addr_sel) < DEPTH) ? mem[addr_sel] : '0;
    assign cpu_ok   = 32'(cpu_addr) < DEPTH;

    assign empty = count == '0;
    assign pop   = s_valid && s_ready;
    // Dropping stream_en mid-frame throws away the FIFO and the word in flight.
    assign flush = state == FETCH && !stream_en;
    assign push  = fly && !flush;
    // Credit counts the in-flight word so the FIFO can never overflow.
    assign issue = state == FETCH && stream_en && !cpu_req && (32'(count) + 32'(fly) < FIFO_DEPTH);
    assign last  = issued == len - AW'(1);
    assign relatch = (state == IDLE || (state == DRAIN && empty && !fly)) && stream_en && frame_len != '0;

    assign s_valid = !empty;
    assign {s_sof, s_eof, s_data} = fifo[rd_ptr];
    assign busy = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = relatch ? FETCH : IDLE;
            FETCH:   state_nx = flush ? IDLE : (issue && last) ? DRAIN : FETCH;
            DRAIN:   state_nx = relatch ? FETCH : (empty && !fly) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpu_req && cpu_we && cpu_ok)
            for (int k = 0; k < R; k++)
                if (cpu_lane_en[k]) mem[cpu_addr][k*N +: N] <= cpu_wd[k*N +: N];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            len          <= '0;
            issued       <= '0;
            fly          <= 1'b0;
            fly_data     <= '0;
            fly_sof      <= 1'b0;
            fly_eof      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cpu_rd       <= '0;
            oor_err      <= 1'b0;
            underrun_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else begin
            state <= state_nx;
            if (relatch) begin
                ptr    <= frame_base;
                len    <= frame_len;
                issued <= '0;
            end else if (issue) begin
                ptr    <= (ptr == LAST) ? '0 : ptr + AW'(1);
                issued <= issued + AW'(1);
            end
            fly <= issue;
            if (issue) begin
                fly_data <= rd_word;
                fly_sof  <= issued == '0;
                fly_eof  <= last;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo[wr_ptr] <= {fly_sof, fly_eof, fly_data};
                    wr_ptr       <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            end
            if (cpu_req && !cpu_ok) oor_err <= 1'b1;
            if (cpu_req && !cpu_we) cpu_rd <= rd_word;
            if (state == FETCH && s_ready && empty && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
endmodule
